muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: WORD_WIDTH, 32, operand/result width; only 32 is supported (RV32M).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  unit can accept a request.
REQ-006 funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 rs1_data  input  32  operand A, from register-file port data_rs1.
REQ-008 rs2_data  input  32  operand B, from register-file port data_rs2.
REQ-009 rd_in  input  5  destination register index.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  writeback accepts result.
REQ-012 out_result  output  32  result, drives register-file data_wr.
REQ-013 out_rd  output  5  destination index, drives register-file rd.
REQ-014 out_wr_en  output  1  register-file write enable.

Function
REQ-015 FSM states are IDLE, CALC and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 Accept: on an edge with in_valid & in_ready, the unit latches funct3, rd_in, operand magnitudes and sign flags, clears the iteration counter, and enters CALC.
REQ-017 CALC performs exactly one iteration per cycle (shift-add multiply or restoring divide) for 32 cycles; on the 32nd CALC edge it applies sign fix-up and enters DONE.
REQ-018 Latency is fixed: out_valid rises exactly 33 edges after the accepting edge, for all ops and operands, including special cases.
REQ-019 DONE holds out_result and out_rd stable until out_ready=1; the handshake edge returns to IDLE.
REQ-020 No new request is accepted in the same cycle as an output handshake; back-to-back throughput is 1 op per 34 cycles.
REQ-021 out_wr_en = out_valid & out_ready & (out_rd != 0), so x0 is never written.
REQ-022 Signedness: MUL/MULH/DIV/REM treat both operands as signed; MULHSU treats rs1 as signed and rs2 as unsigned; MULHU/DIVU/REMU treat both as unsigned.
REQ-023 MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32] of the 64-bit two's-complement product.
REQ-024 Divide by zero: quotient = 32'hFFFF_FFFF (DIV and DIVU); remainder = rs1_data.
REQ-025 Signed overflow (rs1 = 32'h8000_0000, rs2 = 32'hFFFF_FFFF, DIV/REM): quotient = 32'h8000_0000, remainder = 0.
REQ-026 The remainder sign follows the dividend; the quotient is negated when the operand signs differ (excluding REQ-024/REQ-025 cases).
REQ-027 Input changes while in CALC or DONE have no effect on the result.
REQ-028 out_result and out_rd read 0 whenever out_valid=0.

Reset
REQ-029 With rst=1 at an edge: state=IDLE, counter=0, all datapath registers=0; out_valid=0, out_wr_en=0, out_result=0, out_rd=0, in_ready=1 after the edge.
REQ-030 A reset during CALC or DONE aborts the operation; no write is produced and the first accept is possible on the edge after rst deasserts.
REQ-031 rst has priority over every handshake in the same cycle.

Structure
REQ-032 A shared package holds the funct3 op constants, the FSM state typedef, XLEN=32, and ITER_COUNT=32.
REQ-033 One sub-module, muldiv_step, is natural: combinational single-iteration datapath (add/shift or subtract/compare). The FSM, counter and sign fix-up stay in muldiv_unit.

Verification
REQ-034 MUL 7 x -3, out_ready=1 -> out_result=32'hFFFF_FFEB, out_valid 33 edges after accept, out_wr_en=1 for one cycle.
REQ-035 MULH/MULHSU/MULHU with rs1=rs2=32'hFFFF_FFFF -> 32'h0000_0000 / 32'hFFFF_FFFF / 32'hFFFF_FFFE.
REQ-036 DIV -7 / 2 -> 32'hFFFF_FFFD; REM -7 / 2 -> 32'hFFFF_FFFF; DIVU 100 / 0 -> 32'hFFFF_FFFF; REMU 100 / 0 -> 100; DIV 32'h8000_0000 / -1 -> 32'h8000_0000.
REQ-037 Backpressure: out_ready=0 for 10 cycles in DONE -> out_result/out_rd stable, in_ready=0, no write; out_ready=1 -> one write, then IDLE.
REQ-038 rd_in=0 with a MUL -> out_valid=1 but out_wr_en stays 0.
REQ-039 rst asserted at CALC iteration 15 -> no out_valid; a following request completes correctly with 33-edge latency.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
package muldiv_unit_pkg;

    localparam int XLEN       = 32;
    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = $clog2(ITER_COUNT);

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result handshake bundle between issue, muldiv unit and writeback.
interface muldiv_unit_if;
    import muldiv_unit_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_in;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [4:0]      out_rd;
    logic            out_wr_en;

    modport master (
        output in_valid, funct3, rs1_data, rs2_data, rd_in, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_wr_en
    );

    modport slave (
        input  in_valid, funct3, rs1_data, rs2_data, rd_in, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_wr_en
    );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring divide.
module muldiv_step
    import muldiv_unit_pkg::*;
(
    input  logic            is_div_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   rs;
    logic [XLEN+1:0] diff;
    logic            unused_diff_msb;

    // remainder stays below divisor, so a successful subtract fits XLEN bits
    assign unused_diff_msb = diff[XLEN];

    always_comb begin
        sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);
        rs   = {hi_i, lo_i[XLEN-1]};
        diff = {1'b0, rs} - {2'b00, b_i};
        hi_o = sum[XLEN:1];
        lo_o = {sum[0], lo_i[XLEN-1:1]};
        if (is_div_i) begin
            if (diff[XLEN+1]) begin
                hi_o = rs[XLEN-1:0];
                lo_o = {lo_i[XLEN-2:0], 1'b0};
            end else begin
                hi_o = diff[XLEN-1:0];
                lo_o = {lo_i[XLEN-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with fixed 32-iteration latency.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WORD_WIDTH = 32
)
(
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2:0]              op_q, op_d;
    logic [4:0]              rd_q, rd_d;
    logic [WORD_WIDTH-1:0]   hi_q, hi_d;
    logic [WORD_WIDTH-1:0]   lo_q, lo_d;
    logic [WORD_WIDTH-1:0]   b_q, b_d;
    logic [WORD_WIDTH-1:0]   a_q, a_d;
    logic [WORD_WIDTH-1:0]   res_q, res_d;
    logic                    a_neg_q, a_neg_d;
    logic                    b_neg_q, b_neg_d;
    logic                    b_zero_q, b_zero_d;

    logic [WORD_WIDTH-1:0]   step_hi, step_lo;
    logic                    a_sgn, b_sgn;
    logic [2*WORD_WIDTH-1:0] prod, prod_s;
    logic [WORD_WIDTH-1:0]   quo, rem, fix;

    muldiv_step u_step (
        .is_div_i (op_q[2]),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .b_i      (b_q),
        .hi_o     (step_hi),
        .lo_o     (step_lo)
    );

    assign a_sgn = (bus.funct3 != F3_MULHU) && (bus.funct3 != F3_DIVU)
                && (bus.funct3 != F3_REMU);
    assign b_sgn = a_sgn && (bus.funct3 != F3_MULHSU);

    // sign fix-up on the final iteration's outputs
    always_comb begin
        prod   = {step_hi, step_lo};
        prod_s = (a_neg_q ^ b_neg_q) ? -prod : prod;
        quo    = (a_neg_q ^ b_neg_q) ? -step_lo : step_lo;
        rem    = a_neg_q ? -step_hi : step_hi;
        unique case (op_q)
            F3_MUL:           fix = prod_s[WORD_WIDTH-1:0];
            F3_DIV, F3_DIVU:  fix = b_zero_q ? '1 : quo;
            F3_REM, F3_REMU:  fix = b_zero_q ? a_q : rem;
            default:          fix = prod_s[2*WORD_WIDTH-1:WORD_WIDTH];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        a_d      = a_q;
        res_d    = res_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        b_zero_d = b_zero_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_d  = S_CALC;
                    cnt_d    = '0;
                    op_d     = bus.funct3;
                    rd_d     = bus.rd_in;
                    a_d      = bus.rs1_data;
                    a_neg_d  = a_sgn & bus.rs1_data[WORD_WIDTH-1];
                    b_neg_d  = b_sgn & bus.rs2_data[WORD_WIDTH-1];
                    b_zero_d = (bus.rs2_data == '0);
                    hi_d     = '0;
                    lo_d     = a_neg_d ? -bus.rs1_data : bus.rs1_data;
                    b_d      = b_neg_d ? -bus.rs2_data : bus.rs2_data;
                end
            end
            S_CALC: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITER_COUNT - 1)) begin
                    state_d = S_DONE;
                    res_d   = fix;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            a_q      <= '0;
            res_q    <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            a_q      <= a_d;
            res_q    <= res_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            b_zero_q <= b_zero_d;
        end
    end

    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.out_valid  = (state_q == S_DONE);
    assign bus.out_result = bus.out_valid ? res_q : '0;
    assign bus.out_rd     = bus.out_valid ? rd_q : '0;
    assign bus.out_wr_en  = bus.out_valid & bus.out_ready & (rd_q != '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit.
module tb_muldiv_unit;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        string       name;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   wr_cnt;
    int   exp_wr;
    vec_t vecs[$];

    muldiv_unit_if bus();

    muldiv_unit #(.WORD_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.out_wr_en) wr_cnt <= wr_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v);
        int lat;
        @(negedge clk);
        chk({v.name, " in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.funct3   = v.f3;
        bus.rs1_data = v.a;
        bus.rs2_data = v.b;
        bus.rd_in    = v.rd;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.funct3   = ~v.f3;
        bus.rs1_data = ~v.a;
        bus.rs2_data = v.a ^ 32'h5A5A_5A5A;
        bus.rd_in    = ~v.rd;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({v.name, " latency"}, 32'(lat), 32'd33);
        chk({v.name, " result"}, bus.out_result, v.exp);
        chk({v.name, " rd"}, 32'(bus.out_rd), 32'(v.rd));
        chk({v.name, " wr_en"}, 32'(bus.out_wr_en), 32'(v.rd != 5'd0));
        if (v.rd != 5'd0) exp_wr++;
        @(posedge clk);
        #1;
        chk({v.name, " back idle"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int   seen;
        int   wr0;
        vec_t v;
        checks = 0;
        errors = 0;
        wr_cnt = 0;
        exp_wr = 0;

        vecs.push_back('{3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, "mul 7*-3"});
        vecs.push_back('{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'h0000_0000, "mulh -1*-1"});
        vecs.push_back('{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFF, "mulhsu"});
        vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFE, "mulhu"});
        vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, "div -7/2"});
        vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, "rem -7/2"});
        vecs.push_back('{3'b101, 32'd100, 32'd0, 5'd11, 32'hFFFF_FFFF, "divu 100/0"});
        vecs.push_back('{3'b111, 32'd100, 32'd0, 5'd12, 32'd100, "remu 100/0"});
        vecs.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, "div ovf"});
        vecs.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0, "rem ovf"});
        vecs.push_back('{3'b100, 32'd7, 32'd0, 5'd15, 32'hFFFF_FFFF, "div 7/0"});
        vecs.push_back('{3'b110, 32'hFFFF_FFFB, 32'd0, 5'd16, 32'hFFFF_FFFB, "rem -5/0"});
        vecs.push_back('{3'b101, 32'd100, 32'd7, 5'd17, 32'd14, "divu 100/7"});
        vecs.push_back('{3'b111, 32'd100, 32'd7, 5'd18, 32'd2, "remu 100/7"});
        vecs.push_back('{3'b100, 32'd20, 32'hFFFF_FFFA, 5'd19, 32'hFFFF_FFFD, "div 20/-6"});
        vecs.push_back('{3'b110, 32'd20, 32'hFFFF_FFFA, 5'd20, 32'd2, "rem 20/-6"});
        vecs.push_back('{3'b000, 32'h1234_5678, 32'h10, 5'd21, 32'h2345_6780, "mul shift"});
        vecs.push_back('{3'b011, 32'h8000_0000, 32'd4, 5'd22, 32'd2, "mulhu 2^33"});
        vecs.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd23, 32'h4000_0000, "mulh min*min"});
        vecs.push_back('{3'b010, 32'h8000_0000, 32'd2, 5'd24, 32'hFFFF_FFFF, "mulhsu min*2"});
        vecs.push_back('{3'b101, 32'hFFFF_FFFF, 32'd1, 5'd25, 32'hFFFF_FFFF, "divu max/1"});
        vecs.push_back('{3'b000, 32'd9, 32'd9, 5'd0, 32'd81, "mul rd0"});

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.funct3   = 3'b000;
        bus.rs1_data = 32'h0;
        bus.rs2_data = 32'h0;
        bus.rd_in    = 5'd0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset out_result", bus.out_result, 32'd0);
        chk("reset out_rd", 32'(bus.out_rd), 32'd0);
        chk("reset wr_en", 32'(bus.out_wr_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i]);
        end

        // backpressure: hold result in DONE for 10 cycles
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.funct3   = 3'b101;
        bus.rs1_data = 32'd100;
        bus.rs2_data = 32'd7;
        bus.rd_in    = 5'd9;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        seen = 0;
        while (!bus.out_valid && seen < 100) begin
            @(posedge clk);
            #1;
            seen++;
        end
        chk("bp reached done", 32'(bus.out_valid), 32'd1);
        wr0 = wr_cnt;
        bus.in_valid = 1'b1;
        bus.rs1_data = 32'hDEAD_BEEF;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk("bp result", bus.out_result, 32'd14);
            chk("bp rd", 32'(bus.out_rd), 32'd9);
            chk("bp in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp wr_en", 32'(bus.out_wr_en), 32'd0);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        chk("bp wr_en on ready", 32'(bus.out_wr_en), 32'd1);
        @(posedge clk);
        #1;
        exp_wr++;
        chk("bp write count", 32'(wr_cnt - wr0), 32'd1);
        chk("bp idle", 32'(bus.in_ready), 32'd1);
        chk("bp valid low", 32'(bus.out_valid), 32'd0);
        chk("bp result zero", bus.out_result, 32'd0);

        // reset in the middle of CALC aborts the op
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.funct3   = 3'b000;
        bus.rs1_data = 32'd3;
        bus.rs2_data = 32'd4;
        bus.rd_in    = 5'd3;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wr0 = wr_cnt;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        chk("abort no valid", 32'(seen), 32'd0);
        chk("abort no write", 32'(wr_cnt - wr0), 32'd0);
        v = '{3'b000, 32'd3, 32'd4, 5'd3, 32'd12, "post-abort mul"};
        run_op(v);

        chk("total writes", 32'(wr_cnt), 32'(exp_wr));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
